// File: rtl/xxx_fill_gen.sv
// xxx_fill_gen: enable-driven (address, data) word-stream generator; data is a
// progressive all-ones fill that widens by ceil(DATA_WIDTH/4) bits per word.
module xxx_fill_gen #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  dft_tm_i,
    input  logic                  xxx_en_i,
    output logic                  xxx_dt_valid_o,
    output logic [ADDR_WIDTH-1:0] xxx_addr_o,
    output logic [DATA_WIDTH-1:0] xxx_dt_o
);
    localparam int F = (DATA_WIDTH + 3) / 4;
    localparam logic [DATA_WIDTH-1:0] FILL = {DATA_WIDTH{1'b1}} >> (DATA_WIDTH - F);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state_q, state_d;
    logic                    valid_q, valid_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    stop;

    // Test mode behaves exactly like a dropped enable.
    assign stop = !xxx_en_i || dft_tm_i;

    always_comb begin
        state_d = state_q;
        valid_d = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        if (stop) begin
            state_d = IDLE;
            addr_d  = '0;
            data_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = RUN;
                    valid_d = 1'b1;
                    addr_d  = '0;
                    data_d  = FILL;
                end
                RUN: begin
                    if (&addr_q) begin
                        state_d = DONE;
                    end else begin
                        valid_d = 1'b1;
                        addr_d  = addr_q + ADDR_WIDTH'(1);
                        data_d  = (data_q << F) | FILL;
                    end
                end
                default: state_d = DONE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign xxx_dt_valid_o = valid_q;
    assign xxx_addr_o     = addr_q;
    assign xxx_dt_o       = data_q;
endmodule

// File: tb/tb_xxx_fill_gen.sv
// tb_xxx_fill_gen: two configurations (AW=4/DW=8, AW=3/DW=5) driven by the same
// directed and random enable/test-mode stimulus, checked against a run-index model.
module tb_xxx_fill_gen;
    logic       clk = 1'b0, rst_n = 1'b0, tm = 1'b0, en = 1'b0;
    logic       v0, v1;
    logic [3:0] a0;
    logic [7:0] d0;
    logic [2:0] a1;
    logic [4:0] d1;
    int total = 0, bad = 0;
    int ph0 = 0, n0 = 0, ph1 = 0, n1 = 0;

    xxx_fill_gen #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) u0 (
        .clk_i(clk), .rst_n_i(rst_n), .dft_tm_i(tm), .xxx_en_i(en),
        .xxx_dt_valid_o(v0), .xxx_addr_o(a0), .xxx_dt_o(d0));
    xxx_fill_gen #(.ADDR_WIDTH(3), .DATA_WIDTH(5)) u1 (
        .clk_i(clk), .rst_n_i(rst_n), .dft_tm_i(tm), .xxx_en_i(en),
        .xxx_dt_valid_o(v1), .xxx_addr_o(a1), .xxx_dt_o(d1));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ph: 0 idle, 1 emitting word n, 2 finished (holding last word)
    task automatic step(input bit go, input int words, inout int ph, inout int n);
        if (!go) begin ph = 0; n = 0; end
        else if (ph == 0) begin ph = 1; n = 0; end
        else if (ph == 1) begin
            if (n == words - 1) ph = 2;
            else n++;
        end
    endtask

    function automatic logic [31:0] fill(input int ph, input int n, input int dw);
        int k;
        if (ph == 0) return 0;
        k = (n + 1) * ((dw + 3) / 4);
        if (k > dw) k = dw;
        return 32'((64'd1 << k) - 1);
    endfunction

    task automatic check_all();
        chk("v0", v0, ph0 == 1);
        chk("a0", a0, ph0 == 0 ? 0 : n0);
        chk("d0", d0, fill(ph0, n0, 8));
        chk("v1", v1, ph1 == 1);
        chk("a1", a1, ph1 == 0 ? 0 : n1);
        chk("d1", d1, fill(ph1, n1, 5));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        step(en && !tm, 16, ph0, n0);
        step(en && !tm, 8, ph1, n1);
        check_all();
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1 ph0 = 0; n0 = 0; ph1 = 0; n1 = 0;
        check_all();
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #12 check_all();
        @(negedge clk) rst_n = 1'b1;
        tick(); tick();
        en = 1'b1;
        tick(); chk("w0_d0", d0, 8'h03); chk("w0_d1", d1, 5'h03); chk("w0_v", v0, 1'b1);
        tick(); chk("w1_d0", d0, 8'h0F); chk("w1_d1", d1, 5'h0F);
        tick(); chk("w2_d0", d0, 8'h3F); chk("w2_d1", d1, 5'h1F);
        tick(); chk("w3_d0", d0, 8'hFF);
        repeat (13) tick();
        chk("done_v", v0, 1'b0); chk("done_a", a0, 4'hF); chk("done_d", d0, 8'hFF);
        tick();
        en = 1'b0; tick();
        en = 1'b1; repeat (6) tick();
        chk("w5_a", a0, 4'd5);
        en = 1'b0; tick();
        chk("abort_v", v0, 1'b0); chk("abort_a", a0, 4'd0); chk("abort_d", d0, 8'h00);
        en = 1'b1; tick();
        chk("restart_d", d0, 8'h03);
        repeat (3) tick();
        async_reset();
        tm = 1'b1; repeat (5) tick();
        chk("tm_v", v0, 1'b0);
        tm = 1'b0; tick();
        chk("tm_exit_v", v0, 1'b1); chk("tm_exit_a", a0, 4'd0);
        repeat (3000) begin
            en = ($urandom_range(0, 15) != 0);
            tm = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 299) == 0) async_reset();
            tick();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
